// File: rtl/pacman_pkg.sv
// Shared types and widths for the Pacman game-flow logic.
package pacman_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESPAWN   = 3'd1,
        PLAY      = 3'd2,
        DYING     = 3'd3,
        CLEAR     = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;

    localparam int LIVES_W = 3;
    localparam int LEVEL_W = 8;
    localparam int ANIM_W  = 7;
    localparam int TIMER_W = 16;

    localparam logic [ANIM_W-1:0] ANIM_MAX = '1;

endpackage

// File: rtl/pacman_life_ctrl_frame_timer.sv
// Loadable frame down-counter that parks at zero; load takes priority over decrement.
module frame_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         en_i,
    output logic         zero_o,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/pacman_life_ctrl.sv
// Game-flow FSM: play, death, respawn, level clear and game over, plus lives/level counters.
module pacman_life_ctrl
    import pacman_pkg::*;
#(
    parameter int INIT_LIVES   = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int CLEAR_FRAMES = 90,
    parameter int GRACE_FRAMES = 120,
    parameter int MAX_LEVEL    = 255
) (
    input  logic                frame_clk,
    input  logic                reset,
    input  logic                start,
    input  logic                collide,
    input  logic                level_clear,
    output game_state_t         state,
    output logic [LIVES_W-1:0]  lives,
    output logic [LEVEL_W-1:0]  level,
    output logic                freeze,
    output logic                respawn,
    output logic                game_over,
    output logic                grace,
    output logic [ANIM_W-1:0]   anim_frame
);

    game_state_t          state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [ANIM_W-1:0]    anim_q, anim_d;
    logic                 freeze_q, respawn_q, game_over_q;

    logic                 state_change;
    logic                 grace_load, grace_en, grace_zero;
    logic                 anim_load, anim_en, anim_zero;
    logic [TIMER_W-1:0]   anim_value;
    logic [TIMER_W-1:0]   grace_count_unused, anim_count_unused;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        unique case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    lives_d = LIVES_W'(INIT_LIVES);
                    level_d = LEVEL_W'(1);
                    state_d = RESPAWN;
                end
            end
            RESPAWN: state_d = PLAY;
            PLAY: begin
                // A real hit beats a simultaneous level clear.
                if (collide && grace_zero) begin
                    lives_d = lives_q - 1'b1;
                    state_d = DYING;
                end else if (level_clear) begin
                    state_d = CLEAR;
                end
            end
            DYING: begin
                if (anim_zero) begin
                    state_d = (lives_q == '0) ? GAME_OVER : RESPAWN;
                end
            end
            CLEAR: begin
                if (anim_zero) begin
                    if (level_q < LEVEL_W'(MAX_LEVEL)) begin
                        level_d = level_q + 1'b1;
                    end
                    state_d = RESPAWN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_change = (state_d != state_q);

    // The phase timer holds the frames still to run after the current one.
    assign anim_load  = state_change && ((state_d == DYING) || (state_d == CLEAR));
    assign anim_value = (state_d == DYING) ? TIMER_W'(DEATH_FRAMES - 1)
                                           : TIMER_W'(CLEAR_FRAMES - 1);
    assign anim_en    = !state_change && ((state_q == DYING) || (state_q == CLEAR));

    assign grace_load = state_change && (state_d == RESPAWN);
    assign grace_en   = (state_q == PLAY);

    always_comb begin
        anim_d = anim_q;
        if (state_change) begin
            anim_d = '0;
        end else if (((state_q == DYING) || (state_q == CLEAR)) && (anim_q != ANIM_MAX)) begin
            anim_d = anim_q + 1'b1;
        end
    end

    frame_timer #(.W(TIMER_W)) u_anim_timer (
        .clk_i   (frame_clk),
        .rst_ni  (reset),
        .load_i  (anim_load),
        .value_i (anim_value),
        .en_i    (anim_en),
        .zero_o  (anim_zero),
        .count_o (anim_count_unused)
    );

    frame_timer #(.W(TIMER_W)) u_grace_timer (
        .clk_i   (frame_clk),
        .rst_ni  (reset),
        .load_i  (grace_load),
        .value_i (TIMER_W'(GRACE_FRAMES)),
        .en_i    (grace_en),
        .zero_o  (grace_zero),
        .count_o (grace_count_unused)
    );

    always_ff @(posedge frame_clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            lives_q     <= '0;
            level_q     <= '0;
            anim_q      <= '0;
            freeze_q    <= 1'b1;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            anim_q      <= anim_d;
            freeze_q    <= (state_d != PLAY);
            respawn_q   <= (state_d == RESPAWN);
            game_over_q <= (state_d == GAME_OVER);
        end
    end

    assign state      = state_q;
    assign lives      = lives_q;
    assign level      = level_q;
    assign anim_frame = anim_q;
    assign freeze     = freeze_q;
    assign respawn    = respawn_q;
    assign game_over  = game_over_q;
    assign grace      = !grace_zero;

endmodule

// File: tb/tb_pacman_life_ctrl.sv
// Bench for pacman_life_ctrl: directed scenarios then random frames, two parameter sets, reference model.
module tb_pacman_life_ctrl;
    import pacman_pkg::*;

    logic frame_clk;
    logic reset, start, collide, level_clear;

    game_state_t        o_state     [2];
    logic [LIVES_W-1:0] o_lives     [2];
    logic [LEVEL_W-1:0] o_level     [2];
    logic               o_freeze    [2];
    logic               o_respawn   [2];
    logic               o_game_over [2];
    logic               o_grace     [2];
    logic [ANIM_W-1:0]  o_anim      [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per DUT.
    game_state_t m_st [2];
    int m_lives [2];
    int m_level [2];
    int m_grace [2];
    int m_elapsed [2];
    int p_init [2];
    int p_df [2];
    int p_cf [2];
    int p_gr [2];
    int p_max [2];

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    pacman_life_ctrl #(
        .INIT_LIVES(3), .DEATH_FRAMES(60), .CLEAR_FRAMES(90), .GRACE_FRAMES(120), .MAX_LEVEL(255)
    ) dut (
        .frame_clk(frame_clk), .reset(reset), .start(start), .collide(collide),
        .level_clear(level_clear), .state(o_state[0]), .lives(o_lives[0]), .level(o_level[0]),
        .freeze(o_freeze[0]), .respawn(o_respawn[0]), .game_over(o_game_over[0]),
        .grace(o_grace[0]), .anim_frame(o_anim[0])
    );

    pacman_life_ctrl #(
        .INIT_LIVES(3), .DEATH_FRAMES(2), .CLEAR_FRAMES(3), .GRACE_FRAMES(0), .MAX_LEVEL(3)
    ) dut_b (
        .frame_clk(frame_clk), .reset(reset), .start(start), .collide(collide),
        .level_clear(level_clear), .state(o_state[1]), .lives(o_lives[1]), .level(o_level[1]),
        .freeze(o_freeze[1]), .respawn(o_respawn[1]), .game_over(o_game_over[1]),
        .grace(o_grace[1]), .anim_frame(o_anim[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input logic r, input logic s, input logic c, input logic l);
        game_state_t nx;
        if (!r) begin
            m_st[k] = IDLE; m_lives[k] = 0; m_level[k] = 0; m_grace[k] = 0; m_elapsed[k] = 0;
            return;
        end
        nx = m_st[k];
        case (m_st[k])
            IDLE, GAME_OVER: if (s) begin
                m_lives[k] = p_init[k]; m_level[k] = 1; nx = RESPAWN;
            end
            RESPAWN: nx = PLAY;
            PLAY: begin
                if (c && m_grace[k] == 0) begin
                    m_lives[k] = m_lives[k] - 1; nx = DYING;
                end else if (l) begin
                    nx = CLEAR;
                end
                if (m_grace[k] > 0) m_grace[k] = m_grace[k] - 1;
            end
            DYING: if (m_elapsed[k] == p_df[k] - 1) nx = (m_lives[k] == 0) ? GAME_OVER : RESPAWN;
            CLEAR: if (m_elapsed[k] == p_cf[k] - 1) begin
                m_level[k] = (m_level[k] + 1 > p_max[k]) ? p_max[k] : m_level[k] + 1;
                nx = RESPAWN;
            end
            default: nx = IDLE;
        endcase
        if (nx == RESPAWN) m_grace[k] = p_gr[k];
        if (nx != m_st[k]) m_elapsed[k] = 0;
        else if (m_st[k] == DYING || m_st[k] == CLEAR) m_elapsed[k] = m_elapsed[k] + 1;
        m_st[k] = nx;
    endtask

    task automatic check_dut(input int k);
        int ea;
        ea = (m_elapsed[k] > 127) ? 127 : m_elapsed[k];
        chk($sformatf("dut%0d.state", k), 32'(o_state[k]), 32'(m_st[k]));
        chk($sformatf("dut%0d.lives", k), 32'(o_lives[k]), 32'(m_lives[k]));
        chk($sformatf("dut%0d.level", k), 32'(o_level[k]), 32'(m_level[k]));
        chk($sformatf("dut%0d.freeze", k), 32'(o_freeze[k]), 32'(m_st[k] != PLAY));
        chk($sformatf("dut%0d.respawn", k), 32'(o_respawn[k]), 32'(m_st[k] == RESPAWN));
        chk($sformatf("dut%0d.game_over", k), 32'(o_game_over[k]), 32'(m_st[k] == GAME_OVER));
        chk($sformatf("dut%0d.grace", k), 32'(o_grace[k]), 32'(m_grace[k] != 0));
        chk($sformatf("dut%0d.anim", k), 32'(o_anim[k]), 32'(ea));
    endtask

    // One video frame: drive inputs, clock, advance model, sample 1 time unit after the edge.
    task automatic frame(input logic r, input logic s, input logic c, input logic l);
        reset = r; start = s; collide = c; level_clear = l;
        @(posedge frame_clk);
        for (int k = 0; k < 2; k++) model_step(k, r, s, c, l);
        #1;
        for (int k = 0; k < 2; k++) check_dut(k);
        @(negedge frame_clk);
    endtask

    initial begin
        p_init = '{3, 3}; p_df = '{60, 2}; p_cf = '{90, 3}; p_gr = '{120, 0}; p_max = '{255, 3};
        for (int k = 0; k < 2; k++) begin
            m_st[k] = IDLE; m_lives[k] = 0; m_level[k] = 0; m_grace[k] = 0; m_elapsed[k] = 0;
        end
        reset = 1'b0; start = 1'b0; collide = 1'b0; level_clear = 1'b0;
        @(negedge frame_clk);

        // Power-on reset.
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        chk("reset.state", 32'(o_state[0]), 32'(IDLE));
        chk("reset.freeze", 32'(o_freeze[0]), 32'd1);

        // Start, one-frame respawn, then PLAY with grace.
        frame(1, 1, 0, 0);
        chk("start.respawn", 32'(o_respawn[0]), 32'd1);
        frame(1, 0, 0, 0);
        chk("start.state", 32'(o_state[0]), 32'(PLAY));
        chk("start.lives", 32'(o_lives[0]), 32'd3);
        chk("start.grace", 32'(o_grace[0]), 32'd1);
        for (int i = 0; i < 8; i++) frame(1, 0, 0, 0);
        frame(1, 0, 1, 0);
        chk("grace.ignore", 32'(o_state[0]), 32'(PLAY));
        for (int n = 0; n < 200 && m_grace[0] != 0; n++) frame(1, 0, 0, 0);
        chk("grace.expired", 32'(o_grace[0]), 32'd0);
        frame(1, 0, 1, 0);
        chk("hit.state", 32'(o_state[0]), 32'(DYING));
        chk("hit.lives", 32'(o_lives[0]), 32'd2);
        for (int i = 0; i < 59; i++) frame(1, 0, 0, 0);
        chk("hit.last_anim", 32'(o_anim[0]), 32'd59);
        frame(1, 0, 0, 0);
        chk("hit.respawn", 32'(o_respawn[0]), 32'd1);
        frame(1, 0, 0, 0);

        // Reset mid-DYING.
        for (int n = 0; n < 200 && m_grace[0] != 0; n++) frame(1, 0, 0, 0);
        frame(1, 0, 1, 0);
        for (int i = 0; i < 20; i++) frame(1, 0, 0, 0);
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        chk("middie.state", 32'(o_state[0]), 32'(IDLE));
        chk("middie.lives", 32'(o_lives[0]), 32'd0);
        chk("middie.respawn", 32'(o_respawn[0]), 32'd0);

        // No-grace instance: three deaths to game over, then restart.
        frame(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) frame(1, 0, 1, 0);
        chk("gameover.state", 32'(o_state[1]), 32'(GAME_OVER));
        chk("gameover.flag", 32'(o_game_over[1]), 32'd1);
        chk("gameover.lives", 32'(o_lives[1]), 32'd0);
        frame(1, 1, 0, 0);
        chk("restart.state", 32'(o_state[1]), 32'(RESPAWN));
        chk("restart.lives", 32'(o_lives[1]), 32'd3);
        chk("restart.level", 32'(o_level[1]), 32'd1);

        // Collide and level_clear together: collide wins.
        frame(0, 0, 0, 0);
        frame(1, 1, 0, 0);
        for (int i = 0; i < 125; i++) frame(1, 0, 0, 0);
        frame(1, 0, 1, 1);
        chk("both.state", 32'(o_state[0]), 32'(DYING));
        chk("both.lives", 32'(o_lives[0]), 32'd2);
        chk("both.level", 32'(o_level[0]), 32'd1);

        // Climb to the level ceiling, then one more clear at 255.
        frame(0, 0, 0, 0);
        frame(1, 1, 0, 0);
        for (int n = 0; n < 30000 && !(m_st[0] == CLEAR && m_level[0] == 255); n++) frame(1, 0, 0, 1);
        chk("max.enter", 32'(o_state[0]), 32'(CLEAR));
        chk("max.anim0", 32'(o_anim[0]), 32'd0);
        for (int i = 1; i < 90; i++) begin
            frame(1, 0, 0, 0);
            chk($sformatf("max.anim%0d", i), 32'(o_anim[0]), 32'(i));
        end
        frame(1, 0, 0, 0);
        chk("max.exit", 32'(o_state[0]), 32'(RESPAWN));
        chk("max.level", 32'(o_level[0]), 32'd255);
        chk("max.lives", 32'(o_lives[0]), 32'd3);
        chk("max.anim_clr", 32'(o_anim[0]), 32'd0);
        chk("max.b_level", 32'(o_level[1]), 32'd3);

        // Random frames against the model.
        for (int i = 0; i < 4000; i++) begin
            frame(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 7) == 0),
                  logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
